vortex_ccip_tx_buffer_shim: RTL and testbench
=============================================

Name: vortex_ccip_tx_buffer_shim

Overview:
- Parametrised successor to the flat-port CCI-P shim used by the OPAE simulation harness.
- Sits between the AFU's CCI-P Tx request outputs and the flat simulator-facing Tx ports.
- Buffers c0 (read request) and c1 (write request) traffic in per-channel FIFOs and honours the platform TxAlmFull backpressure.
- Regenerates its own almost-full back to the AFU with configurable slack; registers c2 MMIO read responses.

Parameters:
- C0_HDR_W, 74, c0 request header width.
- C1_HDR_W, 80, c1 request header width.
- DATA_W, 512, c1 cache-line data width.
- MMIO_DATA_W, 64, c2 MMIO response data width.
- TID_W, 9, MMIO transaction id width.
- DEPTH, 16, entries per channel FIFO; power of two, >= 4.
- ALM_SLACK, 8, free entries still guaranteed when afu_cX_almfull asserts; must be < DEPTH.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- afu_c0_hdr  in  C0_HDR_W  AFU read request header
- afu_c0_valid  in  1  AFU read request strobe
- afu_c0_almfull  out  1  almost-full to AFU, c0
- afu_c1_hdr  in  C1_HDR_W  AFU write request header
- afu_c1_data  in  DATA_W  AFU write data
- afu_c1_valid  in  1  AFU write request strobe
- afu_c1_almfull  out  1  almost-full to AFU, c1
- afu_c2_tid  in  TID_W  MMIO response tid
- afu_c2_data  in  MMIO_DATA_W  MMIO response data
- afu_c2_valid  in  1  MMIO response strobe
- vcp_c0_almfull  in  1  platform c0 TxAlmFull
- vcp_c1_almfull  in  1  platform c1 TxAlmFull
- af2cp_c0_hdr  out  C0_HDR_W  flat c0 header
- af2cp_c0_valid  out  1  flat c0 valid
- af2cp_c1_hdr  out  C1_HDR_W  flat c1 header
- af2cp_c1_data  out  DATA_W  flat c1 data
- af2cp_c1_valid  out  1  flat c1 valid
- af2cp_c2_tid  out  TID_W  flat c2 tid
- af2cp_c2_data  out  MMIO_DATA_W  flat c2 data
- af2cp_c2_mmioRdValid  out  1  flat c2 valid
- c0_count  out  $clog2(DEPTH+1)  c0 occupancy
- c1_count  out  $clog2(DEPTH+1)  c1 occupancy
- overflow  out  2  sticky drop flags, bit0=c0, bit1=c1

Behaviour:
- Single clock domain. Reset is synchronous and active-high.
- Reset values: all valids 0, counts 0, overflow 0, almfull outputs 0. hdr/data outputs reset to 0.
- FIFOs: each channel is a circular buffer with wrapping read/write pointers. c1 stores hdr and data as one atomic entry.
- Push occurs when afu_cX_valid=1 and (count<DEPTH or a pop happens the same cycle). Push and pop in the same cycle leave count unchanged.
- Full drop: a push while full with no same-cycle pop is dropped. The corresponding overflow bit is set and stays set until reset. FIFO contents are unchanged.
- Pop occurs when count>0 and vcp_cX_almfull=0 in that cycle. The popped entry appears on af2cp_cX_* with af2cp_cX_valid=1 on the next cycle (1-cycle registered output).
- Throughput: at most one request per channel per cycle. af2cp_cX_valid is 0 on any cycle with no pop in the prior cycle. hdr/data hold their last value when valid=0.
- Cut-through minimum latency: AFU valid at cycle N, empty FIFO, almfull low → af2cp valid at cycle N+2 (push N, pop N+1, out N+2).
- AFU almost-full: afu_cX_almfull is registered, equal to 1 when next-count >= DEPTH-ALM_SLACK.
- c0 and c1 are fully independent. No ordering between channels.
- c2 path: registered pass-through, 1-cycle latency, never backpressured, not buffered.
- Reset mid-operation: FIFOs are emptied and in-flight entries are discarded. No valid asserts on the cycle after reset deasserts.
- Counts are reported post-update, i.e. the registered value.

Optional Feature:
- Macro: VX_CCIP_TX_SHIM_PERF_EN.
- When defined, adds outputs perf_c0_stalls and perf_c1_stalls, each 32 bits.
  - Each increments on cycles where count>0 and vcp_cX_almfull=1.
  - Each saturates at 2^32-1 and clears on reset.
- When undefined, the ports and counters are absent. Functional behaviour is otherwise identical.

Test Plan:
- Single c0 push with hdr=0x123, almfull low → af2cp_c0_valid=1 with hdr=0x123 exactly 2 cycles later, for 1 cycle; c0_count returns to 0.
- vcp_c1_almfull=1, push 8 c1 entries (DEPTH=16, ALM_SLACK=8) → afu_c1_almfull=1 the cycle after the 8th push, c1_count=8, no af2cp_c1_valid.
  - Then release almfull → 8 back-to-back valids in push order, data intact.
- Hold vcp_c0_almfull=1, push 17 entries → overflow[0]=1 and c0_count=16.
  - After release, exactly 16 entries emerge: the first 16 pushed.
- Continuous push and pop at full with almfull low for 40 cycles → count constant, no overflow, pointers wrap, output sequence equals input sequence.
- c2 tid=0x5, data=0xDEADBEEF valid for one cycle while both FIFOs are stalled → af2cp_c2_mmioRdValid=1 with the same tid/data the next cycle.
- Assert reset with 5 entries queued in each FIFO → counts 0, no valid out after reset, overflow cleared. A new push is then delivered normally.

Source files
------------

// File: rtl/vortex_ccip_tx_buffer_shim.sv
// vortex_ccip_tx_buffer_shim
//   Buffers CCI-P Tx requests from the AFU in front of the flat simulator ports.
//   c0 (read requests) and c1 (write requests, hdr+data as one entry) each pass
//   through an independent DEPTH-entry FIFO. A channel drains only while the
//   platform TxAlmFull for that channel is low. afu_cX_almfull is regenerated
//   with ALM_SLACK free entries still left when it rises. c2 MMIO read responses
//   are registered once and are never buffered or stalled.
//
// Optional build macro: VX_CCIP_TX_SHIM_PERF_EN adds the saturating 32-bit stall
//   counters perf_c0_stalls / perf_c1_stalls.
//
// Ports
//   clk, reset              clock, synchronous active-high reset
//   afu_c0_* / afu_c1_*     AFU request inputs; afu_cX_almfull back to the AFU
//   afu_c2_*                AFU MMIO read response
//   vcp_c0/c1_almfull       platform backpressure
//   af2cp_c0/c1/c2_*        flat outputs, one registered stage after the pop
//   c0_count, c1_count      registered FIFO occupancy
//   overflow                sticky drop flags, bit0=c0, bit1=c1

module vortex_ccip_tx_buffer_shim_fifo #(
   parameter int unsigned W         = 8,
   parameter int unsigned DEPTH     = 16,
   parameter int unsigned ALM_SLACK = 8,
   parameter int unsigned CNT_W     = $clog2(DEPTH + 1),
   parameter int unsigned PTR_W     = $clog2(DEPTH)
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             push_i,
   input  logic [W-1:0]     data_i,
   input  logic             stall_i,
   output logic             valid_o,
   output logic [W-1:0]     data_o,
   output logic [CNT_W-1:0] count_o,
   output logic             almfull_o,
   output logic             overflow_o
);

   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] ALM_CNT  = CNT_W'(DEPTH - ALM_SLACK);

   logic [W-1:0]     mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] count_q, count_d;
   logic             valid_q, almfull_q, overflow_q;
   logic [W-1:0]     data_q;
   logic             pop, push, drop;

   always_comb begin
      pop     = (count_q != '0) && !stall_i;
      // A full FIFO still accepts when the same cycle frees the slot being written.
      push    = push_i && ((count_q != FULL_CNT) || pop);
      drop    = push_i && (count_q == FULL_CNT) && !pop;
      count_d = count_q;
      if (push && !pop) begin
         count_d = count_q + CNT_W'(1);
      end else if (!push && pop) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) begin
         mem_q[wr_ptr_q] <= data_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         valid_q    <= 1'b0;
         data_q     <= '0;
         almfull_q  <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         count_q   <= count_d;
         almfull_q <= (count_d >= ALM_CNT);
         valid_q   <= pop;
         if (pop) begin
            data_q   <= mem_q[rd_ptr_q];
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         if (push) begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         end
         if (drop) begin
            overflow_q <= 1'b1;
         end
      end
   end

   assign valid_o    = valid_q;
   assign data_o     = data_q;
   assign count_o    = count_q;
   assign almfull_o  = almfull_q;
   assign overflow_o = overflow_q;

endmodule

module vortex_ccip_tx_buffer_shim #(
   parameter int unsigned C0_HDR_W    = 74,
   parameter int unsigned C1_HDR_W    = 80,
   parameter int unsigned DATA_W      = 512,
   parameter int unsigned MMIO_DATA_W = 64,
   parameter int unsigned TID_W       = 9,
   parameter int unsigned DEPTH       = 16,
   parameter int unsigned ALM_SLACK   = 8
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [C0_HDR_W-1:0]          afu_c0_hdr,
   input  logic                         afu_c0_valid,
   output logic                         afu_c0_almfull,
   input  logic [C1_HDR_W-1:0]          afu_c1_hdr,
   input  logic [DATA_W-1:0]            afu_c1_data,
   input  logic                         afu_c1_valid,
   output logic                         afu_c1_almfull,
   input  logic [TID_W-1:0]             afu_c2_tid,
   input  logic [MMIO_DATA_W-1:0]       afu_c2_data,
   input  logic                         afu_c2_valid,
   input  logic                         vcp_c0_almfull,
   input  logic                         vcp_c1_almfull,
   output logic [C0_HDR_W-1:0]          af2cp_c0_hdr,
   output logic                         af2cp_c0_valid,
   output logic [C1_HDR_W-1:0]          af2cp_c1_hdr,
   output logic [DATA_W-1:0]            af2cp_c1_data,
   output logic                         af2cp_c1_valid,
   output logic [TID_W-1:0]             af2cp_c2_tid,
   output logic [MMIO_DATA_W-1:0]       af2cp_c2_data,
   output logic                         af2cp_c2_mmioRdValid,
   output logic [$clog2(DEPTH+1)-1:0]   c0_count,
   output logic [$clog2(DEPTH+1)-1:0]   c1_count,
   output logic [1:0]                   overflow
`ifdef VX_CCIP_TX_SHIM_PERF_EN
   ,
   output logic [31:0]                  perf_c0_stalls,
   output logic [31:0]                  perf_c1_stalls
`endif
);

   localparam int unsigned C1_W = C1_HDR_W + DATA_W;

   logic [C1_W-1:0]        c1_out;
   logic [TID_W-1:0]       c2_tid_q;
   logic [MMIO_DATA_W-1:0] c2_data_q;
   logic                   c2_valid_q;

   vortex_ccip_tx_buffer_shim_fifo #(
      .W         (C0_HDR_W),
      .DEPTH     (DEPTH),
      .ALM_SLACK (ALM_SLACK)
   ) u_c0_fifo (
      .clk_i      (clk),
      .reset_i    (reset),
      .push_i     (afu_c0_valid),
      .data_i     (afu_c0_hdr),
      .stall_i    (vcp_c0_almfull),
      .valid_o    (af2cp_c0_valid),
      .data_o     (af2cp_c0_hdr),
      .count_o    (c0_count),
      .almfull_o  (afu_c0_almfull),
      .overflow_o (overflow[0])
   );

   // Header and data travel together so a c1 entry can never be split.
   vortex_ccip_tx_buffer_shim_fifo #(
      .W         (C1_W),
      .DEPTH     (DEPTH),
      .ALM_SLACK (ALM_SLACK)
   ) u_c1_fifo (
      .clk_i      (clk),
      .reset_i    (reset),
      .push_i     (afu_c1_valid),
      .data_i     ({afu_c1_hdr, afu_c1_data}),
      .stall_i    (vcp_c1_almfull),
      .valid_o    (af2cp_c1_valid),
      .data_o     (c1_out),
      .count_o    (c1_count),
      .almfull_o  (afu_c1_almfull),
      .overflow_o (overflow[1])
   );

   assign af2cp_c1_hdr  = c1_out[C1_W-1:DATA_W];
   assign af2cp_c1_data = c1_out[DATA_W-1:0];

   always_ff @(posedge clk) begin
      if (reset) begin
         c2_valid_q <= 1'b0;
         c2_tid_q   <= '0;
         c2_data_q  <= '0;
      end else begin
         c2_valid_q <= afu_c2_valid;
         if (afu_c2_valid) begin
            c2_tid_q  <= afu_c2_tid;
            c2_data_q <= afu_c2_data;
         end
      end
   end

   assign af2cp_c2_mmioRdValid = c2_valid_q;
   assign af2cp_c2_tid         = c2_tid_q;
   assign af2cp_c2_data        = c2_data_q;

`ifdef VX_CCIP_TX_SHIM_PERF_EN
   logic [31:0] perf_c0_q, perf_c1_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         perf_c0_q <= '0;
         perf_c1_q <= '0;
      end else begin
         if ((c0_count != '0) && vcp_c0_almfull && (perf_c0_q != '1)) begin
            perf_c0_q <= perf_c0_q + 32'd1;
         end
         if ((c1_count != '0) && vcp_c1_almfull && (perf_c1_q != '1)) begin
            perf_c1_q <= perf_c1_q + 32'd1;
         end
      end
   end

   assign perf_c0_stalls = perf_c0_q;
   assign perf_c1_stalls = perf_c1_q;
`else
   // Stall counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_vortex_ccip_tx_buffer_shim.sv
module tb_vortex_ccip_tx_buffer_shim;

   logic          clk = 1'b0;
   logic          reset;
   logic [73:0]   afu_c0_hdr;
   logic          afu_c0_valid;
   logic          afu_c0_almfull;
   logic [79:0]   afu_c1_hdr;
   logic [511:0]  afu_c1_data;
   logic          afu_c1_valid;
   logic          afu_c1_almfull;
   logic [8:0]    afu_c2_tid;
   logic [63:0]   afu_c2_data;
   logic          afu_c2_valid;
   logic          vcp_c0_almfull;
   logic          vcp_c1_almfull;
   logic [73:0]   af2cp_c0_hdr;
   logic          af2cp_c0_valid;
   logic [79:0]   af2cp_c1_hdr;
   logic [511:0]  af2cp_c1_data;
   logic          af2cp_c1_valid;
   logic [8:0]    af2cp_c2_tid;
   logic [63:0]   af2cp_c2_data;
   logic          af2cp_c2_mmioRdValid;
   logic [4:0]    c0_count;
   logic [4:0]    c1_count;
   logic [1:0]    overflow;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   vortex_ccip_tx_buffer_shim #(
      .C0_HDR_W    (74),
      .C1_HDR_W    (80),
      .DATA_W      (512),
      .MMIO_DATA_W (64),
      .TID_W       (9),
      .DEPTH       (16),
      .ALM_SLACK   (8)
   ) dut (
      .clk                  (clk),
      .reset                (reset),
      .afu_c0_hdr           (afu_c0_hdr),
      .afu_c0_valid         (afu_c0_valid),
      .afu_c0_almfull       (afu_c0_almfull),
      .afu_c1_hdr           (afu_c1_hdr),
      .afu_c1_data          (afu_c1_data),
      .afu_c1_valid         (afu_c1_valid),
      .afu_c1_almfull       (afu_c1_almfull),
      .afu_c2_tid           (afu_c2_tid),
      .afu_c2_data          (afu_c2_data),
      .afu_c2_valid         (afu_c2_valid),
      .vcp_c0_almfull       (vcp_c0_almfull),
      .vcp_c1_almfull       (vcp_c1_almfull),
      .af2cp_c0_hdr         (af2cp_c0_hdr),
      .af2cp_c0_valid       (af2cp_c0_valid),
      .af2cp_c1_hdr         (af2cp_c1_hdr),
      .af2cp_c1_data        (af2cp_c1_data),
      .af2cp_c1_valid       (af2cp_c1_valid),
      .af2cp_c2_tid         (af2cp_c2_tid),
      .af2cp_c2_data        (af2cp_c2_data),
      .af2cp_c2_mmioRdValid (af2cp_c2_mmioRdValid),
      .c0_count             (c0_count),
      .c1_count             (c1_count),
      .overflow             (overflow)
   );

   task automatic check(input string tag, input logic [511:0] act, input logic [511:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Advance one clock; outputs are stable 1 ns after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [511:0] mkdata(input int k);
      logic [31:0] w;
      w = 32'hA500_0000 + 32'(k);
      return {16{w}};
   endfunction

   initial begin
      reset          = 1'b1;
      afu_c0_hdr     = '0;
      afu_c0_valid   = 1'b0;
      afu_c1_hdr     = '0;
      afu_c1_data    = '0;
      afu_c1_valid   = 1'b0;
      afu_c2_tid     = '0;
      afu_c2_data    = '0;
      afu_c2_valid   = 1'b0;
      vcp_c0_almfull = 1'b0;
      vcp_c1_almfull = 1'b0;
      repeat (3) tick();

      // Reset state
      check("rst_c0_valid", 512'(af2cp_c0_valid), 512'(0));
      check("rst_c1_valid", 512'(af2cp_c1_valid), 512'(0));
      check("rst_c2_valid", 512'(af2cp_c2_mmioRdValid), 512'(0));
      check("rst_c0_count", 512'(c0_count), 512'(0));
      check("rst_c1_count", 512'(c1_count), 512'(0));
      check("rst_overflow", 512'(overflow), 512'(0));
      check("rst_c0_almfull", 512'(afu_c0_almfull), 512'(0));
      check("rst_c1_almfull", 512'(afu_c1_almfull), 512'(0));
      check("rst_c0_hdr", 512'(af2cp_c0_hdr), 512'(0));
      check("rst_c1_data", af2cp_c1_data, 512'(0));
      reset = 1'b0;
      tick();

      // Single c0 push, cut-through latency of two cycles
      afu_c0_hdr   = 74'h123;
      afu_c0_valid = 1'b1;
      tick();
      afu_c0_valid = 1'b0;
      check("t1_valid_n1", 512'(af2cp_c0_valid), 512'(0));
      check("t1_count_n1", 512'(c0_count), 512'(1));
      tick();
      check("t1_valid_n2", 512'(af2cp_c0_valid), 512'(1));
      check("t1_hdr_n2", 512'(af2cp_c0_hdr), 512'(74'h123));
      check("t1_count_n2", 512'(c0_count), 512'(0));
      tick();
      check("t1_valid_n3", 512'(af2cp_c0_valid), 512'(0));
      check("t1_hdr_hold", 512'(af2cp_c0_hdr), 512'(74'h123));

      // c1 stalled: fill to the almost-full threshold
      vcp_c1_almfull = 1'b1;
      for (int i = 0; i < 8; i++) begin
         afu_c1_hdr   = 80'(16'h100 + i);
         afu_c1_data  = mkdata(i);
         afu_c1_valid = 1'b1;
         tick();
         if (i == 6) check("t2_almfull_after7", 512'(afu_c1_almfull), 512'(0));
      end
      afu_c1_valid = 1'b0;
      check("t2_almfull_after8", 512'(afu_c1_almfull), 512'(1));
      check("t2_count", 512'(c1_count), 512'(8));
      check("t2_no_valid", 512'(af2cp_c1_valid), 512'(0));
      vcp_c1_almfull = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         check("t2_drain_valid", 512'(af2cp_c1_valid), 512'(1));
         check("t2_drain_hdr", 512'(af2cp_c1_hdr), 512'(80'(16'h100 + i)));
         check("t2_drain_data", af2cp_c1_data, mkdata(i));
      end
      tick();
      check("t2_drain_end", 512'(af2cp_c1_valid), 512'(0));
      check("t2_count_end", 512'(c1_count), 512'(0));
      check("t2_almfull_end", 512'(afu_c1_almfull), 512'(0));

      // c0 overflow: 17 pushes into a stalled 16-deep FIFO
      vcp_c0_almfull = 1'b1;
      for (int i = 0; i < 17; i++) begin
         afu_c0_hdr   = 74'(16'h200 + i);
         afu_c0_valid = 1'b1;
         tick();
         if (i == 15) check("t3_no_ovf_at16", 512'(overflow), 512'(0));
      end
      afu_c0_valid = 1'b0;
      check("t3_overflow", 512'(overflow), 512'(2'b01));
      check("t3_count", 512'(c0_count), 512'(16));
      check("t3_no_valid", 512'(af2cp_c0_valid), 512'(0));
      vcp_c0_almfull = 1'b0;
      for (int i = 0; i < 16; i++) begin
         tick();
         check("t3_drain_valid", 512'(af2cp_c0_valid), 512'(1));
         check("t3_drain_hdr", 512'(af2cp_c0_hdr), 512'(74'(16'h200 + i)));
      end
      tick();
      check("t3_drain_end", 512'(af2cp_c0_valid), 512'(0));
      check("t3_ovf_sticky", 512'(overflow), 512'(2'b01));

      // c1 streaming at full occupancy across pointer wrap
      vcp_c1_almfull = 1'b1;
      for (int i = 0; i < 16; i++) begin
         afu_c1_hdr   = 80'(16'h300 + i);
         afu_c1_data  = mkdata(16'h300 + i);
         afu_c1_valid = 1'b1;
         tick();
      end
      check("t4_full_count", 512'(c1_count), 512'(16));
      vcp_c1_almfull = 1'b0;
      for (int j = 0; j < 40; j++) begin
         afu_c1_hdr   = 80'(16'h310 + j);
         afu_c1_data  = mkdata(16'h310 + j);
         afu_c1_valid = 1'b1;
         tick();
         check("t4_count", 512'(c1_count), 512'(16));
         check("t4_valid", 512'(af2cp_c1_valid), 512'(1));
         check("t4_hdr", 512'(af2cp_c1_hdr), 512'(80'(16'h300 + j)));
         check("t4_data", af2cp_c1_data, mkdata(16'h300 + j));
      end
      afu_c1_valid = 1'b0;
      check("t4_no_ovf", 512'(overflow[1]), 512'(0));

      // c2 pass-through while both FIFOs are stalled
      vcp_c0_almfull = 1'b1;
      vcp_c1_almfull = 1'b1;
      afu_c2_tid     = 9'h5;
      afu_c2_data    = 64'hDEAD_BEEF;
      afu_c2_valid   = 1'b1;
      tick();
      afu_c2_valid = 1'b0;
      check("t5_c2_valid", 512'(af2cp_c2_mmioRdValid), 512'(1));
      check("t5_c2_tid", 512'(af2cp_c2_tid), 512'(9'h5));
      check("t5_c2_data", 512'(af2cp_c2_data), 512'(64'hDEAD_BEEF));
      check("t5_c1_stalled", 512'(af2cp_c1_valid), 512'(0));
      tick();
      check("t5_c2_one_cycle", 512'(af2cp_c2_mmioRdValid), 512'(0));

      // Drain c1, then queue five entries per channel and reset mid-flight
      vcp_c1_almfull = 1'b0;
      repeat (17) tick();
      check("t6_c1_drained", 512'(c1_count), 512'(0));
      vcp_c1_almfull = 1'b1;
      for (int i = 0; i < 5; i++) begin
         afu_c0_hdr   = 74'(16'h400 + i);
         afu_c0_valid = 1'b1;
         afu_c1_hdr   = 80'(16'h500 + i);
         afu_c1_data  = mkdata(16'h500 + i);
         afu_c1_valid = 1'b1;
         tick();
      end
      afu_c0_valid = 1'b0;
      afu_c1_valid = 1'b0;
      check("t6_c0_count5", 512'(c0_count), 512'(5));
      check("t6_c1_count5", 512'(c1_count), 512'(5));
      check("t6_ovf_before", 512'(overflow), 512'(2'b01));
      reset = 1'b1;
      tick();
      reset          = 1'b0;
      vcp_c0_almfull = 1'b0;
      vcp_c1_almfull = 1'b0;
      check("t6_c0_count0", 512'(c0_count), 512'(0));
      check("t6_c1_count0", 512'(c1_count), 512'(0));
      check("t6_ovf_clear", 512'(overflow), 512'(0));
      tick();
      check("t6_c0_no_valid", 512'(af2cp_c0_valid), 512'(0));
      check("t6_c1_no_valid", 512'(af2cp_c1_valid), 512'(0));
      check("t6_c0_still0", 512'(c0_count), 512'(0));
      afu_c0_hdr   = 74'h77;
      afu_c0_valid = 1'b1;
      afu_c1_hdr   = 80'h88;
      afu_c1_data  = mkdata(16'h88);
      afu_c1_valid = 1'b1;
      tick();
      afu_c0_valid = 1'b0;
      afu_c1_valid = 1'b0;
      check("t6_new_c0_n1", 512'(af2cp_c0_valid), 512'(0));
      tick();
      check("t6_new_c0_valid", 512'(af2cp_c0_valid), 512'(1));
      check("t6_new_c0_hdr", 512'(af2cp_c0_hdr), 512'(74'h77));
      check("t6_new_c1_valid", 512'(af2cp_c1_valid), 512'(1));
      check("t6_new_c1_hdr", 512'(af2cp_c1_hdr), 512'(80'h88));
      check("t6_new_c1_data", af2cp_c1_data, mkdata(16'h88));
      tick();
      check("t6_new_c0_end", 512'(af2cp_c0_valid), 512'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
